// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 pixel type and pulse-timing constants (cycles) from clock rate
package ws2812_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic int ws2812_mhz(input int clk_speed);
    return clk_speed / 1_000_000;
  endfunction

  // Integer form of truncating MHZ*0.4 and MHZ*0.8.
  function automatic int ws2812_tshort(input int clk_speed);
    return (ws2812_mhz(clk_speed) * 4) / 10;
  endfunction

  function automatic int ws2812_tlong(input int clk_speed);
    return (ws2812_mhz(clk_speed) * 8) / 10;
  endfunction

  function automatic int ws2812_tthr(input int clk_speed);
    return (ws2812_tshort(clk_speed) + ws2812_tlong(clk_speed)) / 2;
  endfunction

  function automatic int ws2812_tmin(input int clk_speed);
    return ws2812_tshort(clk_speed) / 2;
  endfunction

  function automatic int ws2812_tmax(input int clk_speed);
    return 2 * ws2812_tlong(clk_speed);
  endfunction

  function automatic int ws2812_tres(input int clk_speed, input int res_us);
    return ws2812_mhz(clk_speed) * res_us;
  endfunction

endpackage

// File: rtl/ws2812_rx_sync_2ff.sv
// rtl/ws2812_rx_sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire decoder: pulse-width bits to GRB pixels, frame-gap detect
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_SPEED = 27_000_000,
  parameter int RES_US    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ws2812_i,
  output logic       valid,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [9:0] pix_idx,
  output logic       frame_end,
  output logic       err
);

  localparam logic [15:0] TTHR = 16'(ws2812_tthr(CLK_SPEED));
  localparam logic [15:0] TMIN = 16'(ws2812_tmin(CLK_SPEED));
  localparam logic [15:0] TMAX = 16'(ws2812_tmax(CLK_SPEED));
  localparam logic [15:0] TRES = 16'(ws2812_tres(CLK_SPEED, RES_US));

  typedef enum logic [1:0] {RESYNC, IDLE, HIGH, LOW} state_e;

  logic        line;
  logic        line_q, line_d;
  logic        rise, fall;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] shift_q, shift_d, shift_in;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  grb_t        pix_q, pix_d;
  logic [9:0]  pix_idx_q, pix_idx_d;
  logic        valid_q, valid_d;
  logic        frame_end_q, frame_end_d;
  logic        err_q, err_d;
  logic        bit_val;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ws2812_i),
    .q   (line)
  );

  assign rise = line & ~line_q;
  assign fall = ~line & line_q;

  always_comb begin
    line_d      = line;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    pix_cnt_d   = pix_cnt_q;
    pix_d       = pix_q;
    pix_idx_d   = pix_idx_q;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    bit_val     = (cnt_q >= TTHR);
    shift_in    = {shift_q[22:0], bit_val};

    case (state_q)
      RESYNC: begin
        if (line) begin
          cnt_d = 16'd0;
        end else if (cnt_q == TRES) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
        end
      end

      HIGH: begin
        if (fall) begin
          if (cnt_q < TMIN) begin
            err_d     = 1'b1;
            state_d   = RESYNC;
            cnt_d     = 16'd0;
            bitcnt_d  = 5'd0;
            pix_cnt_d = 10'd0;
          end else begin
            shift_d = shift_in;
            state_d = LOW;
            cnt_d   = 16'd1;
            if (bitcnt_q == 5'd23) begin
              valid_d   = 1'b1;
              pix_d     = shift_in;
              pix_idx_d = pix_cnt_q;
              pix_cnt_d = (pix_cnt_q == 10'd1023) ? pix_cnt_q : pix_cnt_q + 10'd1;
              bitcnt_d  = 5'd0;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end else if (cnt_inc > TMAX) begin
          // Stuck-high line: report once, then RESYNC keeps clearing while it stays high.
          err_d     = 1'b1;
          state_d   = RESYNC;
          cnt_d     = 16'd0;
          bitcnt_d  = 5'd0;
          pix_cnt_d = 10'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      LOW: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = 16'd1;
        end else if (cnt_q >= TRES) begin
          frame_end_d = 1'b1;
          err_d       = (bitcnt_q != 5'd0);
          bitcnt_d    = 5'd0;
          pix_cnt_d   = 10'd0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = RESYNC;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q      <= 1'b0;
      state_q     <= RESYNC;
      cnt_q       <= 16'd0;
      bitcnt_q    <= 5'd0;
      shift_q     <= 24'd0;
      pix_cnt_q   <= 10'd0;
      pix_q       <= '0;
      pix_idx_q   <= 10'd0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      line_q      <= line_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      pix_cnt_q   <= pix_cnt_d;
      pix_q       <= pix_d;
      pix_idx_q   <= pix_idx_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  assign valid     = valid_q;
  assign r         = pix_q.r;
  assign g         = pix_q.g;
  assign b         = pix_q.b;
  assign pix_idx   = pix_idx_q;
  assign frame_end = frame_end_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard bench for ws2812_rx: directed pulse trains, queued expected strobes
module tb_ws2812_rx;

  localparam int K_PIX = 0;
  localparam int K_FE  = 1;
  localparam int K_ERR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ws  = 1'b0;
  logic       valid;
  logic [7:0] r, g, b;
  logic [9:0] pix_idx;
  logic       frame_end;
  logic       err;

  always #5 clk = ~clk;

  ws2812_rx #(.CLK_SPEED(27_000_000), .RES_US(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .ws2812_i  (ws),
    .valid     (valid),
    .r         (r),
    .g         (g),
    .b         (b),
    .pix_idx   (pix_idx),
    .frame_end (frame_end),
    .err       (err)
  );

  typedef struct {
    int         kind;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         idx;
    bit         ferr;
    int         gap;
    bit         line_hi;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pix(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb, input int idx);
    exp_t x;
    x = '{K_PIX, pr, pg, pb, idx, 1'b0, -1, 1'b0};
    q.push_back(x);
  endtask

  task automatic push_fe(input bit ferr, input int gap);
    exp_t x;
    x = '{K_FE, 8'h0, 8'h0, 8'h0, 0, ferr, gap, 1'b0};
    q.push_back(x);
  endtask

  task automatic push_err(input bit line_hi);
    exp_t x;
    x = '{K_ERR, 8'h0, 8'h0, 8'h0, 0, 1'b0, -1, line_hi};
    q.push_back(x);
  endtask

  // Monitor: every strobe must match the head of the expected queue, in order.
  always @(negedge clk) begin
    if (!rst && (valid || frame_end || err)) begin
      if (valid && (frame_end || err)) begin
        chk("valid_exclusive", 64'({valid, frame_end, err}), 64'(3'b100));
      end else if (q.size() == 0) begin
        chk("unexpected_strobe", 64'({valid, frame_end, err}), 64'(0));
      end else begin
        e = q.pop_front();
        if (valid) begin
          chk("kind_pix", 64'(K_PIX), 64'(e.kind));
          if (e.kind == K_PIX)
            chk("pixel_rgb_idx", 64'({r, g, b, pix_idx}), 64'({e.r, e.g, e.b, 10'(e.idx)}));
          last_valid_cyc = cyc;
        end else if (frame_end) begin
          chk("kind_fe", 64'(K_FE), 64'(e.kind));
          chk("fe_err", 64'(err), 64'(e.ferr));
          if (e.gap >= 0) chk("fe_gap", 64'(cyc - last_valid_cyc), 64'(e.gap));
        end else begin
          chk("kind_err", 64'(K_ERR), 64'(e.kind));
          if (e.line_hi) chk("err_line_high", 64'(ws), 64'(1));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    ws = 1'b1;
    tick(h);
    ws = 1'b0;
    tick(l);
  endtask

  task automatic send_bits(input logic [23:0] d, input int n,
                           input int h0, input int l0, input int h1, input int l1);
    for (int i = 0; i < n; i++) begin
      if (d[23-i]) pulse(h1, l1);
      else         pulse(h0, l0);
    end
  endtask

  task automatic send_px(input logic [23:0] d);
    send_bits(d, 24, 10, 24, 21, 13);
  endtask

  initial begin
    rst = 1'b1;
    ws  = 1'b0;
    tick(4);
    rst = 1'b0;
    chk("rst_strobes", 64'({valid, frame_end, err}), 64'(0));
    chk("rst_rgb", 64'({r, g, b}), 64'(0));
    chk("rst_idx", 64'(pix_idx), 64'(0));
    tick(1400);

    // Nominal pixel, frame end exactly TRES after decode.
    push_pix(8'h12, 8'h34, 8'h56, 0);
    push_fe(1'b0, 1350);
    send_px(24'h341256);
    tick(100);
    chk("hold_rgb_idx", 64'({r, g, b, pix_idx}), 64'({8'h12, 8'h34, 8'h56, 10'd0}));
    tick(1400);

    // Two back-to-back pixels, single frame end.
    push_pix(8'h0F, 8'hA5, 8'hF0, 0);
    push_pix(8'h80, 8'h01, 8'hFF, 1);
    push_fe(1'b0, -1);
    send_px(24'hA50FF0);
    send_px(24'h0180FF);
    tick(1450);

    // Threshold pixel (14 -> 0, 15 -> 1), then a 4-cycle runt.
    push_pix(8'h3C, 8'hC3, 8'h99, 0);
    push_err(1'b0);
    send_bits(24'hC33C99, 24, 14, 20, 15, 19);
    pulse(4, 30);

    // Ignored while resyncing, then pixel with min/max legal widths.
    send_bits(24'hF0F0F0, 5, 10, 24, 21, 13);
    tick(1400);
    push_pix(8'h22, 8'h11, 8'h33, 0);
    push_err(1'b0);
    send_bits(24'h112233, 24, 5, 30, 42, 10);
    pulse(43, 30);
    tick(1400);

    // Line stuck high: one err while still high, nothing else.
    push_err(1'b1);
    ws = 1'b1;
    tick(300);
    ws = 1'b0;
    tick(1400);

    // Partial pixel: frame_end with err, then index restarts at 0.
    push_fe(1'b1, -1);
    push_pix(8'h55, 8'hAA, 8'h0F, 0);
    push_fe(1'b0, 1350);
    send_bits(24'hFFF000, 12, 10, 24, 21, 13);
    tick(1400);
    send_px(24'hAA550F);
    tick(1400);

    // Reset mid-pixel with an uninterrupted stream afterwards.
    send_bits(24'h123456, 8, 10, 24, 21, 13);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send_bits(24'h789ABC, 16, 10, 24, 21, 13);
    send_px(24'hDEF012);
    tick(1400);
    push_pix(8'hDC, 8'hFE, 8'hBA, 0);
    push_fe(1'b0, 1350);
    send_px(24'hFEDCBA);
    tick(1450);

    tick(50);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
